// File: rtl/mult_pkg.sv
// Shared types and constants for the add/shift multiplier controller.
package mult_pkg;

  localparam int N_BITS_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
  } mult_state_t;

  // Counter width, kept at least one bit so a 1-bit multiply still elaborates.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_bit_cnt.sv
// Iteration counter for the multiplier: clear, saturating increment, terminal flag.
module mult_bit_cnt
  import mult_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       clr,
  input  logic                       inc,
  output logic [cnt_w(N_BITS)-1:0]   cnt,
  output logic                       last
);

  localparam int CW = cnt_w(N_BITS);
  localparam logic [CW-1:0] LAST_V = CW'(N_BITS - 1);

  assign last = (cnt == LAST_V);

  // Holding at the terminal value keeps the count from wrapping mid-run.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !last) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mult_ctrl.sv
// Sequencer for an add/shift multiplier; CLR stage present only with MULT_CTRL_AUTOCLR_EN.
// Handshake: Run is a level request sampled in IDLE; Done stays high in HOLD until Run drops.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       Run,
  input  logic                       ClearA_LoadB,
  input  logic                       M,
  output logic                       Clr_XA,
  output logic                       Ld_B,
  output logic                       Add_En,
  output logic                       Sub_En,
  output logic                       Shift_En,
  output logic                       Busy,
  output logic                       Done,
  output logic [2:0]                 dbg_state,
  output logic [cnt_w(N_BITS)-1:0]   dbg_cnt
);

  mult_state_t               state;
  mult_state_t               state_nxt;
  logic [cnt_w(N_BITS)-1:0]  cnt;
  logic                      cnt_last;
  logic                      cnt_clr;
  logic                      cnt_inc;

  assign cnt_clr = (state == S_IDLE) && Run;
  assign cnt_inc = (state == S_SHIFT);

  mult_bit_cnt #(.N_BITS(N_BITS)) u_bit_cnt (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .last    (cnt_last)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Run) begin
`ifdef MULT_CTRL_AUTOCLR_EN
          state_nxt = S_CLR;
`else
          state_nxt = S_ADD;
`endif
        end
      end
      S_CLR:   state_nxt = S_ADD;
      S_ADD:   state_nxt = S_SHIFT;
      S_SHIFT: state_nxt = cnt_last ? S_HOLD : S_ADD;
      S_HOLD:  if (!Run) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // All strobes are forced low while reset is asserted, whatever the state.
  always_comb begin
    Clr_XA   = 1'b0;
    Ld_B     = 1'b0;
    Add_En   = 1'b0;
    Sub_En   = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    if (Reset_n) begin
      case (state)
        S_IDLE: begin
          Clr_XA = ClearA_LoadB;
          Ld_B   = ClearA_LoadB;
        end
        S_CLR: begin
          Clr_XA = 1'b1;
          Busy   = 1'b1;
        end
        S_ADD: begin
          Busy   = 1'b1;
          Add_En = M && !cnt_last;
          Sub_En = M && cnt_last;
        end
        S_SHIFT: begin
          Shift_En = 1'b1;
          Busy     = 1'b1;
        end
        S_HOLD:  Done = 1'b1;
        default: ;
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl; strobe vector is {Clr_XA,Ld_B,Add_En,Sub_En,Shift_En,Busy,Done}.
module tb_mult_ctrl;
  import mult_pkg::*;

  localparam int NB = 8;
`ifdef MULT_CTRL_AUTOCLR_EN
  localparam int LAT = 2 * NB + 1;
`else
  localparam int LAT = 2 * NB;
`endif

  logic       Clk;
  logic       Reset_n;
  logic       Run;
  logic       ClearA_LoadB;
  logic       M;
  logic       Clr_XA, Ld_B, Add_En, Sub_En, Shift_En, Busy, Done;
  logic [2:0] dbg_state;
  logic [2:0] dbg_cnt;

  logic [6:0] exp_q[$];
  int         checks;
  int         passed;

  mult_ctrl #(.N_BITS(NB)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_XA       (Clr_XA),
    .Ld_B         (Ld_B),
    .Add_En       (Add_En),
    .Sub_En       (Sub_En),
    .Shift_En     (Shift_En),
    .Busy         (Busy),
    .Done         (Done),
    .dbg_state    (dbg_state),
    .dbg_cnt      (dbg_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [6:0] obs_vec();
    return {Clr_XA, Ld_B, Add_En, Sub_En, Shift_En, Busy, Done};
  endfunction

  // Expected strobes k edges after the edge that sampled Run in IDLE.
  function automatic logic [6:0] exp_step(input int k, input logic [NB-1:0] b);
    int   kk;
    int   j;
    logic add_v;
    logic sub_v;
`ifdef MULT_CTRL_AUTOCLR_EN
    if (k == 0) return 7'b1000010;
    kk = k - 1;
`else
    kk = k;
`endif
    if (kk >= 2 * NB) return 7'b0000001;
    j = kk / 2;
    if ((kk % 2) == 1) return 7'b0000110;
    add_v = b[j] && (j < NB - 1);
    sub_v = b[j] && (j == NB - 1);
    return {2'b00, add_v, sub_v, 1'b0, 1'b1, 1'b0};
  endfunction

  task automatic run_mult(input string name, input logic [NB-1:0] b, input int hold_cyc,
                          input bit noise, input bit cla_start);
    logic [NB-1:0] b_sh;
    logic [6:0]    exp_v;
    logic [6:0]    obs_v;
    bit            was_shift;
    int            last_k;
    b_sh   = b;
    last_k = LAT + hold_cyc + 1;
    exp_q.push_back({cla_start, cla_start, 5'b00000});
    for (int k = 0; k <= LAT; k++) exp_q.push_back(exp_step(k, b));
    for (int h = 0; h < hold_cyc; h++) exp_q.push_back(7'b0000001);
    exp_q.push_back(7'b0000000);

    @(negedge Clk);
    Run = 1'b1;
    ClearA_LoadB = cla_start;
    M = b_sh[0];
    #1;
    obs_v = obs_vec();
    exp_v = exp_q.pop_front();
    checks++;
    if (obs_v !== exp_v) $display("FAIL %s idle_start: got %b expected %b", name, obs_v, exp_v);
    else passed++;

    @(posedge Clk);
    was_shift = 1'b0;
    for (int k = 0; k <= last_k; k++) begin
      #1;
      if (was_shift) b_sh = b_sh >> 1;
      M = b_sh[0];
      ClearA_LoadB = (noise && k < last_k) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      obs_v = obs_vec();
      exp_v = exp_q.pop_front();
      checks++;
      if (obs_v !== exp_v)
        $display("FAIL %s step%0d: got %b expected %b", name, k, obs_v, exp_v);
      else passed++;
      was_shift = exp_v[2];
      if (k == last_k - 1) begin
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
      end
      @(posedge Clk);
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    Run = 1'b1;
    ClearA_LoadB = 1'b1;
    M = 1'b1;
    repeat (3) @(posedge Clk);
    #2;
    checks++;
    if (obs_vec() !== 7'b0) $display("FAIL reset_strobes: got %b expected 0000000", obs_vec());
    else passed++;
    checks++;
    if (dbg_state !== 3'(S_IDLE) || dbg_cnt !== 3'd0)
      $display("FAIL reset_state: got state %0d cnt %0d expected 0 0", dbg_state, dbg_cnt);
    else passed++;
    @(negedge Clk);
    Reset_n = 1'b1;
    Run = 1'b0;
    ClearA_LoadB = 1'b0;
    M = 1'b0;
    @(posedge Clk);
    #2;
    checks++;
    if (obs_vec() !== 7'b0 || dbg_state !== 3'(S_IDLE))
      $display("FAIL reset_release: got %b state %0d expected 0000000 state 0", obs_vec(), dbg_state);
    else passed++;
  endtask

  task automatic test_clear_load();
    @(negedge Clk);
    ClearA_LoadB = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== 7'b1100000) $display("FAIL idle_clr_ld: got %b expected 1100000", obs_vec());
    else passed++;
    ClearA_LoadB = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 7'b0) $display("FAIL idle_clr_ld_off: got %b expected 0000000", obs_vec());
    else passed++;
    run_mult("cla_with_run", 8'h3C, 0, 1'b0, 1'b1);
    run_mult("cla_noise", 8'hA5, 2, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset();
    int target;
    target = LAT - 2 * NB + 7;
    @(negedge Clk);
    Run = 1'b1;
    M = 1'b1;
    @(posedge Clk);
    for (int k = 0; k < target; k++) @(posedge Clk);
    #2;
    checks++;
    if (dbg_state !== 3'(S_SHIFT) || dbg_cnt !== 3'd3)
      $display("FAIL mid_reset_pos: got state %0d cnt %0d expected 3 3", dbg_state, dbg_cnt);
    else passed++;
    Reset_n = 1'b0;
    Run = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== 7'b0) $display("FAIL mid_reset_gate: got %b expected 0000000", obs_vec());
    else passed++;
    @(posedge Clk);
    #2;
    checks++;
    if (obs_vec() !== 7'b0 || dbg_state !== 3'(S_IDLE) || dbg_cnt !== 3'd0)
      $display("FAIL mid_reset_idle: got %b state %0d cnt %0d expected 0000000 0 0",
               obs_vec(), dbg_state, dbg_cnt);
    else passed++;
    Reset_n = 1'b1;
    repeat (3) @(posedge Clk);
    #2;
    checks++;
    if (obs_vec() !== 7'b0 || dbg_state !== 3'(S_IDLE))
      $display("FAIL mid_reset_stay: got %b state %0d expected 0000000 0", obs_vec(), dbg_state);
    else passed++;
    run_mult("after_reset", 8'($urandom_range(0, 255)), 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_mult("b2b_a", 8'hFF, 0, 1'b0, 1'b0);
    run_mult("b2b_b", 8'h01, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      run_mult("random", 8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    run_mult("b05", 8'h05, 0, 1'b0, 1'b0);
    run_mult("b80", 8'h80, 0, 1'b0, 1'b0);
    run_mult("hold40", 8'h5A, 40 - LAT - 1, 1'b0, 1'b0);
    run_mult("rerun", 8'h81, 0, 1'b0, 1'b0);
    test_clear_load();
    test_mid_reset();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mult_ctrl.md
MULT_CTRL -- requirements
Module: mult_ctrl

Interface
REQ-001 SHALL have parameter N_BITS, default 8: operand width, i.e. the number of add/shift iterations per run.
REQ-002 SHALL have port Clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1: reset is synchronous and active-low.
REQ-004 SHALL have port Run, input, 1: level request to start one multiply.
REQ-005 SHALL have port ClearA_LoadB, input, 1: operator request to clear A/X and load B; honoured only in IDLE.
REQ-006 SHALL have port M, input, 1: current multiplier LSB, taken from the B register's shift-out.
REQ-007 SHALL have port Clr_XA, output, 1: synchronous clear strobe to the X flop and the A register.
REQ-008 SHALL have port Ld_B, output, 1: load strobe to the B register.
REQ-009 SHALL have port Add_En, output, 1: latch A+S into X:A this cycle.
REQ-010 SHALL have port Sub_En, output, 1: latch A-S into X:A this cycle.
REQ-011 SHALL have port Shift_En, output, 1: shift X:A:B right one bit this cycle.
REQ-012 SHALL have port Busy, output, 1: high in CLR, ADD and SHIFT.
REQ-013 SHALL have port Done, output, 1: high in HOLD.

Function
REQ-014 SHALL implement states IDLE, CLR, ADD, SHIFT and HOLD, plus a bit counter cnt of width $clog2(N_BITS).
REQ-015 IDLE SHALL go to CLR when Run=1 and otherwise stay in IDLE; on entry to CLR, cnt SHALL be cleared to 0.
REQ-016 CLR SHALL assert Clr_XA for exactly one cycle, then go to ADD.
REQ-017 ADD SHALL last one cycle, assert Add_En = M when cnt<N_BITS-1, assert Sub_En = M when cnt==N_BITS-1, then go to SHIFT.
REQ-018 Add_En and Sub_En SHALL never be high in the same cycle.
REQ-019 SHALL drive Add_En and Sub_En low outside ADD.
REQ-020 SHALL use M combinationally in ADD; M is stable there because B shifts only in SHIFT.
REQ-021 SHIFT SHALL assert Shift_En for exactly one cycle; if cnt==N_BITS-1 it SHALL go to HOLD, else cnt SHALL increment and the block SHALL go to ADD.
REQ-022 The counter SHALL NOT wrap during a run.
REQ-023 HOLD SHALL stay in HOLD while Run=1 and go to IDLE when Run=0, so a held Run never restarts a multiply.
REQ-024 Latency SHALL be fixed: 1+2*N_BITS cycles from the IDLE cycle in which Run is sampled high to HOLD (17 for N_BITS=8), independent of operand values.
REQ-025 In IDLE, Clr_XA and Ld_B SHALL both equal ClearA_LoadB (combinational), and Shift_En, Add_En and Sub_En SHALL be 0.
REQ-026 ClearA_LoadB SHALL be ignored in every state other than IDLE.
REQ-027 If Run and ClearA_LoadB are both high in IDLE, the load/clear strobes SHALL fire that cycle and the block SHALL still go to CLR on the next edge.
REQ-028 Shift_En, Clr_XA and the add/sub strobes SHALL be mutually exclusive, except that Clr_XA and Ld_B may coincide in IDLE.

Reset
REQ-029 When Reset_n is sampled 0, the next state SHALL be IDLE and cnt SHALL be 0, regardless of current state, including mid-run.
REQ-030 While Reset_n=0, Clr_XA, Add_En, Sub_En, Shift_En, Busy and Done SHALL all be 0, and Ld_B SHALL be 0.
REQ-031 After Reset_n returns to 1, a new run SHALL require Run to be sampled high in IDLE.

Configuration
REQ-032 When MULT_CTRL_AUTOCLR_EN is defined, the CLR state SHALL exist as in REQ-016, and the latency SHALL be 1+2*N_BITS.
REQ-033 When MULT_CTRL_AUTOCLR_EN is not defined, IDLE SHALL go directly to ADD with cnt=0 and Clr_XA SHALL assert only via ClearA_LoadB in IDLE.
REQ-034 Without MULT_CTRL_AUTOCLR_EN, the latency SHALL be 2*N_BITS, and consecutive runs SHALL accumulate into A.

Structure
REQ-035 The state enum (mult_state_t) and the default N_BITS constant SHALL live in shared package mult_pkg, which the datapath top also imports.
REQ-036 The bit counter (clear, increment, terminal flag at N_BITS-1) SHALL be sub-module mult_bit_cnt.
REQ-037 The FSM next-state logic and the output decode SHALL stay in mult_ctrl.

Verification
REQ-038 Scenario: N_BITS=8, M sequence for B=8'h05 (LSB first 1,0,1,0,0,0,0,0) -> Add_En high in ADD visits 0 and 2 only, Sub_En never high, 8 Shift_En pulses, Done at cycle 17.
REQ-039 Scenario: B=8'h80 -> Add_En never high, Sub_En high only in ADD visit 7, Done at cycle 17.
REQ-040 Scenario: Run held 1 for 40 cycles -> exactly one run; block stays in HOLD; after Run drops, IDLE on the next edge; Run reasserted -> new CLR.
REQ-041 Scenario: Reset_n=0 in SHIFT with cnt=3 -> next cycle IDLE, all strobes 0, cnt=0; a later run takes the full 17 cycles.
REQ-042 Scenario: ClearA_LoadB=1 in IDLE -> Clr_XA=Ld_B=1 the same cycle; ClearA_LoadB=1 during ADD/SHIFT -> no Ld_B and no extra Clr_XA.
REQ-043 Scenario: macro undefined -> no CLR cycle, Done at cycle 16, Clr_XA never high during Busy.
